str_ds_capture_ctrl: RTL and testbench
======================================

# str_ds_capture_ctrl

Frame-capture sequencer placed between the stream down-sampler's master port and the DMA/stream sink. It keeps the down-sampler drained while idle, aligns capture to a frame boundary (tlast), forwards exactly a programmed number of LAST-sample frames, and then stops and signals completion. It also checks frame length and flags backpressure stalls.

## Interface
Parameters:
- DW, 24, sample width (signed)
- LAST, 16000, samples per frame (expected tlast spacing)
- NW, 16, width of frame-count configuration and status

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  DW  signed samples from down-sampler
- s_axis_tlast  in  1  frame end from down-sampler
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  upstream ready
- m_axis_tdata  out  DW  captured samples
- m_axis_tlast  out  1  frame end, forwarded
- m_axis_tvalid  out  1  downstream valid
- m_axis_tready  in  1  downstream ready
- cfg_start  in  1  single-cycle capture request
- cfg_stop  in  1  single-cycle abort request (frame-graceful)
- cfg_nframes  in  NW  frames to capture; sampled on cfg_start
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on return to IDLE
- frame_cnt  out  NW  frames forwarded in current/last capture
- frame_err  out  1  sticky: tlast spacing != LAST
- stall_err  out  1  sticky: s_axis_tvalid high with s_axis_tready low in RUN

## Operation
- States: IDLE, SYNC, RUN, DRAIN.
- IDLE: s_axis_tready=1, input beats discarded. cfg_start with cfg_nframes!=0 -> SYNC; latch nframes, clear frame_cnt, frame_err, stall_err. cfg_start with cfg_nframes==0 -> stays IDLE, done pulses the next cycle.
- SYNC: s_axis_tready=1, beats discarded. Accepted beat with tlast=1 -> RUN; the next beat is sample 0 of frame 0. cfg_stop -> IDLE with done.
- RUN: s_axis_tready = skid-buffer ready; accepted beats go to the output skid buffer unchanged (data and tlast).
  - A beat counter tracks position in the frame (0..LAST-1).
  - On an accepted tlast beat: frame_cnt+1. If the new frame_cnt == nframes, or a stop is pending, -> DRAIN.
  - cfg_stop in RUN sets stop_pend. The current frame completes; partial frames are never emitted.
- DRAIN: s_axis_tready=1, input discarded. When the skid buffer is empty -> IDLE, done=1 for one cycle.
- Frame check, RUN only:
  - tlast on a beat index != LAST-1 sets frame_err.
  - Index LAST-1 without tlast sets frame_err.
  - In both cases the counter resynchronises: it resets on every tlast and wraps at LAST-1.
- frame_cnt holds its value after done until the next accepted cfg_start.
- cfg_start while busy is ignored. cfg_start and cfg_stop together in IDLE: start wins.

## Timing
- Reset values: s_axis_tready=1 (state IDLE), m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, busy=0, done=0, frame_cnt=0, frame_err=0, stall_err=0.
- Reset mid-capture aborts immediately. The skid buffer is emptied with no done pulse.
- cfg_start at cycle t -> busy=1 at t+1.
- Data latency s->m is 1 cycle. Full throughput is one beat per clock with m_axis_tready held high.
- s_axis_tready in RUN is registered: it is the skid buffer's not-full flag and has no combinational path from m_axis_tready.
- AXI-stream rules on the m side:
  - m_axis_tdata/tlast stay stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
- done asserts the cycle after the last output beat has handshaked and the buffer is empty; busy falls in the same cycle.
- frame_cnt updates the cycle after the accepted input tlast beat. This is input-side counting, so it can lead the output by up to 2 beats.

## Structure
- Package str_ds_pkg: state enum (IDLE, SYNC, RUN, DRAIN), default DW/LAST/NW constants.
- Sub-module str_axis_skid: 2-entry skid buffer, parameter DW+1 (data+last), ports clk/rst_n, s/m valid-ready, empty flag.
- Top holds the FSM, beat counter ($clog2(LAST) bits), frame counter and the sticky flags.

## Test plan
- LAST=8, nframes=3, input starts mid-frame at index 5, m_tready=1 -> first output is index 0 after the tlast, 24 beats out, 3 tlasts, done once, frame_cnt=3, frame_err=0.
- Same, with m_tready toggling 1-0-1-1 -> all 24 beats in order with no duplicates, stall_err=1, data stable while stalled.
- nframes=5, cfg_stop at beat 3 of frame 1 -> frame 1 completes, 16 beats out, done, frame_cnt=2.
- Inject tlast at index 4 of frame 0 (LAST=8) -> frame_err=1 and sticky. The following properly spaced frames are still forwarded.
- cfg_start with nframes=0 -> no output, busy stays 0, done pulses 1 cycle later.
- rst_n low during RUN with the buffer full -> m_axis_tvalid=0 at once, state IDLE, no done. A new capture after reset behaves normally.

Source files
------------

// File: rtl/str_ds_capture_ctrl_pkg.sv
// Shared types and default sizing for the down-sampler capture sequencer.
package str_ds_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, RUN, DRAIN} state_e;
  localparam int DEF_DW   = 24;
  localparam int DEF_LAST = 16000;
  localparam int DEF_NW   = 16;
endpackage

// File: rtl/str_ds_capture_ctrl_if.sv
// AXI-stream style beat channel (data + last) with valid/ready handshake.
import str_ds_pkg::*;

interface str_ds_capture_ctrl_if #(parameter int DW = DEF_DW);
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/str_axis_skid.sv
// Two-entry skid buffer; ready is the registered not-full flag, so the
// upstream ready never depends combinationally on the downstream ready.
module str_axis_skid #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_s_data,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  output logic [W-1:0] o_m_data,
  output logic         o_m_valid,
  input  logic         i_m_ready,
  output logic         o_empty
);
  logic [1:0][W-1:0] r_mem;
  logic              r_wp, r_rp;
  logic [1:0]        r_cnt;
  logic              w_push, w_pop;

  assign o_s_ready = (r_cnt != 2'd2);
  assign o_m_valid = (r_cnt != 2'd0);
  assign o_empty   = (r_cnt == 2'd0);
  assign o_m_data  = r_mem[r_rp];
  assign w_push    = i_s_valid & o_s_ready;
  assign w_pop     = o_m_valid & i_m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_s_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/str_ds_capture_ctrl.sv
// Frame-aligned capture sequencer: syncs on tlast, forwards N whole frames,
// drains the skid buffer, then pulses done. Also flags bad frame spacing/stalls.
module str_ds_capture_ctrl
  import str_ds_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int LAST = DEF_LAST,
  parameter int NW   = DEF_NW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  str_ds_capture_ctrl_if.slave  s_axis,
  str_ds_capture_ctrl_if.master m_axis,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  input  logic [NW-1:0]        cfg_nframes,
  output logic                 busy,
  output logic                 done,
  output logic [NW-1:0]        frame_cnt,
  output logic                 frame_err,
  output logic                 stall_err
);
  localparam int             BW       = (LAST > 1) ? $clog2(LAST) : 1;
  localparam logic [BW-1:0]  BEAT_MAX = BW'(LAST - 1);

  state_e        r_state, w_state_nxt;
  logic [NW-1:0] r_nframes, r_frame_cnt, w_frame_cnt_inc;
  logic [BW-1:0] r_beat;
  logic          r_stop_pend, r_done, r_frame_err, r_stall_err, w_done_nxt;
  logic          w_in_rdy, w_acc, w_run_acc;
  logic          w_skid_s_ready, w_skid_m_valid, w_skid_empty;
  logic [DW:0]   w_skid_m_data;

  // Outside RUN the input is always drained so the down-sampler never backs up.
  assign w_in_rdy        = (r_state == RUN) ? w_skid_s_ready : 1'b1;
  assign w_acc           = s_axis.tvalid & w_in_rdy;
  assign w_run_acc       = (r_state == RUN) & w_acc;
  assign w_frame_cnt_inc = r_frame_cnt + NW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_nframes != '0) w_state_nxt = SYNC;
          else                   w_done_nxt  = 1'b1;
        end
      end
      SYNC: begin
        if (cfg_stop) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_acc && s_axis.tlast) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_run_acc && s_axis.tlast &&
            ((w_frame_cnt_inc == r_nframes) || r_stop_pend || cfg_stop))
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_skid_empty) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_done      <= 1'b0;
      r_nframes   <= '0;
      r_frame_cnt <= '0;
      r_beat      <= '0;
      r_stop_pend <= 1'b0;
      r_frame_err <= 1'b0;
      r_stall_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (r_state == IDLE && cfg_start) begin
        r_nframes   <= cfg_nframes;
        r_frame_cnt <= '0;
        r_frame_err <= 1'b0;
        r_stall_err <= 1'b0;
        r_stop_pend <= 1'b0;
      end
      if (r_state == SYNC) r_beat <= '0;
      if (r_state == RUN) begin
        if (cfg_stop) r_stop_pend <= 1'b1;
        if (s_axis.tvalid && !w_skid_s_ready) r_stall_err <= 1'b1;
        // Counter resyncs on every tlast and wraps at LAST-1 on a missing one.
        if (w_run_acc) begin
          if (s_axis.tlast) begin
            r_frame_cnt <= w_frame_cnt_inc;
            r_beat      <= '0;
            if (r_beat != BEAT_MAX) r_frame_err <= 1'b1;
          end else if (r_beat == BEAT_MAX) begin
            r_frame_err <= 1'b1;
            r_beat      <= '0;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
      end
    end
  end

  str_axis_skid #(.W(DW + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_s_data  ({s_axis.tdata, s_axis.tlast}),
    .i_s_valid (s_axis.tvalid & (r_state == RUN)),
    .o_s_ready (w_skid_s_ready),
    .o_m_data  (w_skid_m_data),
    .o_m_valid (w_skid_m_valid),
    .i_m_ready (m_axis.tready),
    .o_empty   (w_skid_empty)
  );

  assign s_axis.tready = w_in_rdy;
  assign m_axis.tdata  = w_skid_m_data[DW:1];
  assign m_axis.tlast  = w_skid_m_data[0];
  assign m_axis.tvalid = w_skid_m_valid;
  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign frame_cnt     = r_frame_cnt;
  assign frame_err     = r_frame_err;
  assign stall_err     = r_stall_err;
endmodule

// File: tb/tb_str_ds_capture_ctrl.sv
// Randomized scoreboard bench for str_ds_capture_ctrl (LAST=8).
module tb_str_ds_capture_ctrl;
  localparam int DW = 24, LAST = 8, NW = 8;

  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_start = 1'b0, cfg_stop = 1'b0;
  logic [NW-1:0] cfg_nframes = '0;
  logic busy, done, frame_err, stall_err;
  logic [NW-1:0] frame_cnt;

  str_ds_capture_ctrl_if #(.DW(DW)) s_if ();
  str_ds_capture_ctrl_if #(.DW(DW)) m_if ();

  str_ds_capture_ctrl #(.DW(DW), .LAST(LAST), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_nframes(cfg_nframes),
    .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .frame_err(frame_err), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  int    n_chk = 0, n_fail = 0, done_cnt = 0, rmode = 0, ph = 0;
  beat_t exp_q[$];
  logic  prev_stall = 1'b0;
  logic [DW:0] held = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Downstream ready: 0=always, 1=pattern 1-0-1-1, 2=random, 3=never
  always @(posedge clk) begin
    #1;
    ph = ph + 1;
    case (rmode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = ((ph % 4) != 1);
      2:       m_if.tready = 1'($urandom_range(1, 0));
      default: m_if.tready = 1'b0;
    endcase
  end

  // Output monitor: scoreboard pop, AXI hold rules, done counting
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_if.tvalid, 1);
        check("hold_data", {m_if.tdata, m_if.tlast}, held);
      end
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out_unexpected got=%0h exp=none", {m_if.tdata, m_if.tlast});
        end else begin
          check("out_beat", {m_if.tdata, m_if.tlast}, exp_q.pop_front());
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      held       = {m_if.tdata, m_if.tlast};
      if (done) done_cnt++;
    end
  end

  // Builds the input stream, predicts the forwarded frames, drives and checks.
  task automatic run_capture(input int nfr, input int sidx, input int extra,
                             input int short_at, input int stop_f, input int stop_b,
                             input int rm, input int exp_stall, input string tag);
    beat_t in_q[$];
    beat_t fr[$];
    beat_t b;
    int    stop_pos = -1, fc = 0, base = 0, cyc = 0;
    bit    fe = 0, synced = 0, stopped = 0, fin = 0, hs = 0, abort = 0;
    for (int i = sidx; i < LAST; i++) begin
      b.d = DW'($urandom); b.l = (i == LAST - 1); in_q.push_back(b);
    end
    for (int f = 0; f < nfr + extra; f++) begin
      int len;
      len = (f == 0 && short_at >= 0) ? short_at + 1 : LAST;
      for (int i = 0; i < len; i++) begin
        if (f == stop_f && i == stop_b) stop_pos = in_q.size();
        b.d = DW'($urandom); b.l = (i == len - 1); in_q.push_back(b);
      end
    end
    // Model: skip to first tlast, then forward whole frames until count or stop.
    for (int k = 0; k < in_q.size() && !fin; k++) begin
      if (!synced) begin
        if (in_q[k].l) synced = 1;
      end else begin
        fr.push_back(in_q[k]);
        if (k == stop_pos) stopped = 1;
        if (in_q[k].l) begin
          foreach (fr[j]) exp_q.push_back(fr[j]);
          if (fr.size() != LAST) fe = 1;
          fr.delete();
          fc++;
          if (fc == nfr || stopped) fin = 1;
        end
      end
    end
    rmode = rm;
    @(posedge clk); #1;
    base = done_cnt; cfg_start = 1'b1; cfg_nframes = NW'(nfr);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1);
    for (int k = 0; k < in_q.size() && !abort; k++) begin
      s_if.tdata = in_q[k].d; s_if.tlast = in_q[k].l; s_if.tvalid = 1'b1;
      cfg_stop = (k == stop_pos);
      hs = 0; cyc = 0;
      while (!hs && !abort) begin
        @(negedge clk); hs = s_if.tready;
        @(posedge clk); #1; cfg_stop = 1'b0; cyc++;
        if (cyc > 500) begin
          n_chk++; n_fail++; abort = 1;
          $display("FAIL %s_input_timeout got=stuck exp=accept", tag);
        end
      end
    end
    s_if.tvalid = 1'b0;
    cyc = 0;
    while (done_cnt == base && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    repeat (4) @(posedge clk); #1;
    check({tag, "_done_cnt"}, done_cnt - base, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_frame_cnt"}, frame_cnt, fc);
    check({tag, "_frame_err"}, frame_err, fe);
    if (exp_stall >= 0) check({tag, "_stall_err"}, stall_err, exp_stall);
    check({tag, "_all_out"}, exp_q.size(), 0);
    exp_q.delete();
    rmode = 0;
  endtask

  initial begin
    int base;
    s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_if.tready, 1);
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_errs", {frame_err, stall_err}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_capture(3, 5, 1, -1, -1, -1, 0, 0, "basic");
    run_capture(3, 5, 1, -1, -1, -1, 1, 1, "toggle");
    run_capture(5, 5, 0, -1, 1, 3, 0, 0, "stop");
    run_capture(3, 5, 1, 4, -1, -1, 0, 0, "shortfrm");
    check("ferr_sticky", frame_err, 1);

    // nframes=0: nothing forwarded, done one cycle after start
    @(posedge clk); #1;
    base = done_cnt; cfg_start = 1'b1; cfg_nframes = '0; s_if.tvalid = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    @(posedge clk); #1;
    check("zero_done_pulse", done, 0);
    repeat (4) @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    check("zero_no_out", m_if.tvalid, 0);
    check("zero_done_once", done_cnt - base, 1);

    // Reset mid-RUN with the skid buffer full
    rmode = 3;
    @(posedge clk); #1;
    base = done_cnt; cfg_start = 1'b1; cfg_nframes = NW'(3);
    @(posedge clk); #1;
    cfg_start = 1'b0; s_if.tvalid = 1'b1; s_if.tlast = 1'b1; s_if.tdata = DW'($urandom);
    @(posedge clk); #1;
    s_if.tlast = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("full_s_tready", s_if.tready, 0);
    check("full_m_tvalid", m_if.tvalid, 1);
    @(negedge clk); rst_n = 1'b0; s_if.tvalid = 1'b0;
    #1;
    check("arst_m_tvalid", m_if.tvalid, 0);
    check("arst_busy", busy, 0);
    check("arst_s_tready", s_if.tready, 1);
    rmode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    check("arst_no_done", done_cnt - base, 0);
    repeat (2) @(posedge clk);
    run_capture(2, 3, 1, -1, -1, -1, 0, 0, "post_rst");

    for (int r = 0; r < 3; r++)
      run_capture(int'($urandom_range(4, 1)), int'($urandom_range(LAST - 1, 0)), 1,
                  -1, -1, -1, 2, -1, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
